// File: rtl/sd_ram_bridge_pkg.sv
// Shared types and helpers for the SD ADMA RAM-port to system-bus bridge.
package sd_ram_bridge_pkg;

  typedef enum logic [1:0] {
    SDRB_IDLE    = 2'd0,
    SDRB_RD_REQ  = 2'd1,
    SDRB_RD_WAIT = 2'd2,
    SDRB_WR_REQ  = 2'd3
  } sdrb_state_e;

  localparam int unsigned HOST_ADDR_W = 64;
  localparam int unsigned BUS_DATA_W  = 32;

  // Host address must be word aligned and fit inside the bus address space.
  function automatic logic addr_illegal(input logic [HOST_ADDR_W-1:0] addr,
                                        input int unsigned addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> addr_w) != '0);
  endfunction

endpackage

// File: rtl/sd_bus_timer.sv
// Bus timeout counter: cleared on state entry, counts while enabled.
module sd_bus_timer
  import sd_ram_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the last allowed wait cycle, so a state waits TIMEOUT cycles in total.
  assign expired = en && (cnt_q == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/sd_ram_bridge.sv
// Converts SD host ADMA RAM strobes into single outstanding req/gnt/rvalid bus
// transactions, stalling the host with STOP and reporting sticky errors.
module sd_ram_bridge
  import sd_ram_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [63:0]       ram_address,
  input  logic              ram_read_enable,
  input  logic              ram_write_enable,
  input  logic [31:0]       data_to_ram,
  output logic [31:0]       data_from_ram,
  output logic              STOP,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  input  logic              err_clear,
  output logic              err_timeout,
  output logic              err_range,
  output logic              err_collision
);

  sdrb_state_e       state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              stop_q, stop_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              e_to_q, e_to_d;
  logic              e_rg_q, e_rg_d;
  logic              e_col_q, e_col_d;
  logic              set_to, set_rg, set_col;
  logic              tmr_expired;

  sd_bus_timer #(
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) u_timer (
    .clk    (CLK),
    .rst    (RESET),
    .clr    (state_d != state_q),
    .en     (state_q != SDRB_IDLE),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    stop_d  = stop_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    set_to  = 1'b0;
    set_rg  = 1'b0;
    set_col = 1'b0;

    if (state_q == SDRB_IDLE) begin
      if (ram_read_enable && ram_write_enable) begin
        set_col = 1'b1;
      end else if (ram_read_enable || ram_write_enable) begin
        if (addr_illegal(ram_address, ADDR_W)) begin
          set_rg = 1'b1;
        end else begin
          addr_d  = {ram_address[ADDR_W-1:2], 2'b00};
          we_d    = ram_write_enable;
          wdata_d = ram_write_enable ? data_to_ram : wdata_q;
          req_d   = 1'b1;
          stop_d  = 1'b1;
          state_d = ram_read_enable ? SDRB_RD_REQ : SDRB_WR_REQ;
        end
      end
    end else if (ram_read_enable || ram_write_enable) begin
      set_col = 1'b1;
    end

    case (state_q)
      SDRB_WR_REQ: begin
        if (bus_gnt || tmr_expired) begin
          set_to  = !bus_gnt;
          req_d   = 1'b0;
          stop_d  = 1'b0;
          state_d = SDRB_IDLE;
        end
      end
      SDRB_RD_REQ: begin
        if (bus_gnt) begin
          req_d = 1'b0;
          if (bus_rvalid) begin
            rdata_d = bus_rdata;
            stop_d  = 1'b0;
            state_d = SDRB_IDLE;
          end else begin
            state_d = SDRB_RD_WAIT;
          end
        end else if (tmr_expired) begin
          set_to  = 1'b1;
          req_d   = 1'b0;
          stop_d  = 1'b0;
          state_d = SDRB_IDLE;
        end
      end
      SDRB_RD_WAIT: begin
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          stop_d  = 1'b0;
          state_d = SDRB_IDLE;
        end else if (tmr_expired) begin
          set_to  = 1'b1;
          stop_d  = 1'b0;
          state_d = SDRB_IDLE;
        end
      end
      default: ;
    endcase

    // A new error in the same cycle as err_clear must survive the clear.
    e_to_d  = (e_to_q  && !err_clear) || set_to;
    e_rg_d  = (e_rg_q  && !err_clear) || set_rg;
    e_col_d = (e_col_q && !err_clear) || set_col;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= SDRB_IDLE;
      rdata_q <= '0;
      stop_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      e_to_q  <= 1'b0;
      e_rg_q  <= 1'b0;
      e_col_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      stop_q  <= stop_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      e_to_q  <= e_to_d;
      e_rg_q  <= e_rg_d;
      e_col_q <= e_col_d;
    end
  end

  assign data_from_ram = rdata_q;
  assign STOP          = stop_q;
  assign bus_req       = req_q;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign err_timeout   = e_to_q;
  assign err_range     = e_rg_q;
  assign err_collision = e_col_q;

endmodule

// File: tb/tb_sd_ram_bridge.sv
// Directed bench for sd_ram_bridge with a transaction-level reference model.
module tb_sd_ram_bridge;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [63:0] ram_address;
  logic        ram_read_enable, ram_write_enable;
  logic [31:0] data_to_ram, data_from_ram;
  logic        STOP, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        err_clear, err_timeout, err_range, err_collision;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  sd_ram_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TMR_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .ram_address(ram_address),
    .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
    .data_to_ram(data_to_ram), .data_from_ram(data_from_ram), .STOP(STOP),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .err_clear(err_clear), .err_timeout(err_timeout), .err_range(err_range),
    .err_collision(err_collision)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction, tracked by whether the bus has
  // granted it and how long it has waited in its current phase.
  bit          m_busy, m_read, m_granted, m_we;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_data;
  bit          m_eto, m_erg, m_ecol;
  bit          s_to, s_rg, s_col;

  always @(posedge CLK) begin
    if (RESET) begin
      m_busy = 0; m_read = 0; m_granted = 0; m_we = 0; m_age = 0;
      m_addr = '0; m_wdata = '0; m_data = '0;
      m_eto = 0; m_erg = 0; m_ecol = 0;
    end else begin
      s_to = 0; s_rg = 0; s_col = 0;
      if (!m_busy) begin
        if (ram_read_enable && ram_write_enable) s_col = 1;
        else if (ram_read_enable || ram_write_enable) begin
          if (ram_address[1:0] != 2'b00 || ram_address[63:32] != 32'd0) s_rg = 1;
          else begin
            m_busy = 1; m_read = ram_read_enable; m_granted = 0; m_age = 0;
            m_addr = ram_address[31:0]; m_we = ram_write_enable;
            if (ram_write_enable) m_wdata = data_to_ram;
          end
        end
      end else begin
        if (ram_read_enable || ram_write_enable) s_col = 1;
        if (!m_granted && bus_gnt) begin
          if (!m_read) m_busy = 0;
          else if (bus_rvalid) begin m_data = bus_rdata; m_busy = 0; end
          else begin m_granted = 1; m_age = 0; end
        end else if (m_granted && bus_rvalid) begin
          m_data = bus_rdata; m_busy = 0;
        end else if (m_age == TIMEOUT - 1) begin
          s_to = 1; m_busy = 0;
        end else begin
          m_age++;
        end
      end
      m_eto  = (m_eto  && !err_clear) || s_to;
      m_erg  = (m_erg  && !err_clear) || s_rg;
      m_ecol = (m_ecol && !err_clear) || s_col;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("m_data", data_from_ram, m_data);
      check("m_stop", STOP, m_busy);
      check("m_req", bus_req, m_busy && !m_granted);
      check("m_we", bus_we, m_we);
      check("m_addr", bus_addr, m_addr);
      check("m_wdata", bus_wdata, m_wdata);
      check("m_eto", err_timeout, m_eto);
      check("m_erg", err_range, m_erg);
      check("m_ecol", err_collision, m_ecol);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1; ram_address = '0; ram_read_enable = 0; ram_write_enable = 0;
    data_to_ram = '0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0; err_clear = 0;
    repeat (2) @(negedge CLK);
    RESET = 0; cmp_en = 1;
    check("rst_stop", STOP, 0); check("rst_req", bus_req, 0);
    check("rst_data", data_from_ram, 0); check("rst_errs", {err_timeout, err_range, err_collision}, 0);

    // 1: write, gnt two cycles after req
    ram_address = 64'h1000; data_to_ram = 32'hDEADBEEF; ram_write_enable = 1;
    @(negedge CLK); ram_write_enable = 0;
    check("t1_req", bus_req, 1); check("t1_we", bus_we, 1);
    check("t1_addr", bus_addr, 32'h1000); check("t1_wdata", bus_wdata, 32'hDEADBEEF);
    check("t1_stop0", STOP, 1);
    @(negedge CLK); check("t1_stop1", STOP, 1);
    @(negedge CLK); check("t1_stop2", STOP, 1); bus_gnt = 1;
    @(negedge CLK); bus_gnt = 0;
    check("t1_stop3", STOP, 0); check("t1_req_off", bus_req, 0);
    check("t1_errs", {err_timeout, err_range, err_collision}, 0);

    // 2: read, immediate gnt, rvalid three cycles later
    ram_address = 64'h2004; ram_read_enable = 1;
    @(negedge CLK); ram_read_enable = 0; bus_gnt = 1;
    check("t2_addr", bus_addr, 32'h2004); check("t2_we", bus_we, 0);
    @(negedge CLK); bus_gnt = 0; check("t2_wait_req", bus_req, 0); check("t2_wait_stop", STOP, 1);
    @(negedge CLK);
    @(negedge CLK); bus_rvalid = 1; bus_rdata = 32'hA5A50001;
    @(negedge CLK); bus_rvalid = 0;
    check("t2_data", data_from_ram, 32'hA5A50001); check("t2_stop", STOP, 0);

    // 3: misaligned and out-of-range reads
    ram_address = 64'h2003; ram_read_enable = 1;
    @(negedge CLK); ram_read_enable = 0;
    check("t3_rg1", err_range, 1); check("t3_req1", bus_req, 0); err_clear = 1;
    @(negedge CLK); err_clear = 0; check("t3_clr1", err_range, 0);
    ram_address = 64'h1_0000_0000; ram_read_enable = 1;
    @(negedge CLK); ram_read_enable = 0;
    check("t3_rg2", err_range, 1); check("t3_req2", bus_req, 0); err_clear = 1;
    @(negedge CLK); err_clear = 0; check("t3_clr2", err_range, 0);

    // 4: collisions during RD_WAIT and in IDLE
    ram_address = 64'h3000; ram_read_enable = 1;
    @(negedge CLK); ram_read_enable = 0; bus_gnt = 1;
    @(negedge CLK); bus_gnt = 0; ram_address = 64'h4000; ram_write_enable = 1;
    @(negedge CLK); ram_write_enable = 0;
    check("t4_col", err_collision, 1); check("t4_stop", STOP, 1);
    bus_rvalid = 1; bus_rdata = 32'h0BADF00D;
    @(negedge CLK); bus_rvalid = 0;
    check("t4_data", data_from_ram, 32'h0BADF00D); check("t4_addr", bus_addr, 32'h3000);
    ram_read_enable = 1; ram_write_enable = 1; err_clear = 1;
    @(negedge CLK); ram_read_enable = 0; ram_write_enable = 0; err_clear = 0;
    check("t4_setwins", err_collision, 1); check("t4_noreq", bus_req, 0);
    err_clear = 1;
    @(negedge CLK); err_clear = 0; check("t4_clr", err_collision, 0);

    // 5: write never granted, then a read whose rvalid never arrives
    ram_address = 64'h5000; data_to_ram = 32'h11112222; ram_write_enable = 1;
    @(negedge CLK); ram_write_enable = 0;
    repeat (3) @(negedge CLK);
    check("t5_stop_last", STOP, 1); check("t5_to_early", err_timeout, 0);
    @(negedge CLK);
    check("t5_to", err_timeout, 1); check("t5_stop", STOP, 0); check("t5_req", bus_req, 0);
    bus_rvalid = 1; bus_rdata = 32'hFFFFFFFF;
    @(negedge CLK); bus_rvalid = 0;
    check("t5_stray", data_from_ram, 32'h0BADF00D); err_clear = 1;
    ram_address = 64'h6000; ram_read_enable = 1;
    @(negedge CLK); ram_read_enable = 0; err_clear = 0; bus_gnt = 1;
    check("t5_to_clr", err_timeout, 0);
    @(negedge CLK); bus_gnt = 0;
    repeat (4) @(negedge CLK);
    check("t5_rd_to", err_timeout, 1); check("t5_rd_stop", STOP, 0);
    bus_rvalid = 1; bus_rdata = 32'h55555555;
    @(negedge CLK); bus_rvalid = 0;
    check("t5_late", data_from_ram, 32'h0BADF00D);

    // 6: reset while waiting for read data
    ram_address = 64'h7000; ram_read_enable = 1;
    @(negedge CLK); ram_read_enable = 0; bus_gnt = 1;
    @(negedge CLK); bus_gnt = 0; RESET = 1;
    @(negedge CLK); RESET = 0;
    check("t6_data", data_from_ram, 0); check("t6_stop", STOP, 0);
    check("t6_addr", bus_addr, 0); check("t6_errs", {err_timeout, err_range, err_collision}, 0);
    bus_rvalid = 1; bus_rdata = 32'h1234;
    @(negedge CLK); bus_rvalid = 0;
    check("t6_ignored", data_from_ram, 0); check("t6_stop2", STOP, 0);
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
